usr_c2h_gen: RTL
================

USR_C2H_GEN -- requirements
Module: usr_c2h_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, C2H stream data width in bits; must be a multiple of 32.
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, byte-enable width.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port run_i, input, 1, generator enable; a level, sampled on its rising edge.
REQ-006 SHALL have port pkt_len_i, input, 16, packet length in bytes.
REQ-007 SHALL have port pkt_num_i, input, 16, packets per run; 0 means continuous.
REQ-008 SHALL have port s0_axis_c2h_tready_i, input, 1, C2H sink ready.
REQ-009 SHALL have port s0_axis_c2h_tdata_o, output, DATA_WIDTH, C2H data.
REQ-010 SHALL have ports s0_axis_c2h_tkeep_o and s0_axis_c2h_tuser_o, output, KEEP_WIDTH each, byte enables and user bits.
REQ-011 SHALL have ports s0_axis_c2h_tlast_o and s0_axis_c2h_tvalid_o, output, 1 each, end of packet and valid.
REQ-012 SHALL have port busy_o, output, 1, high in any state other than IDLE.
REQ-013 SHALL have port done_o, output, 1, one-cycle pulse when a run ends.
REQ-014 SHALL have port pkt_cnt_o, output, 16, count of completed packets in the current run.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, SEND and DONE.
REQ-016 SHALL go IDLE->LOAD on the first cycle run_i is sampled high after being sampled low (registered edge detect).
REQ-017 SHALL, in LOAD, latch pkt_len_i and pkt_num_i, clear pkt_cnt_o and the beat counter, and go to SEND on the next edge.
REQ-018 SHALL assert tvalid_o only in SEND; first tvalid_o is high 2 cycles after the edge that samples the run_i rise.
REQ-019 SHALL treat a latched length of 0 as 1 byte.
REQ-020 SHALL use a beat count per packet of ceil(len/KEEP_WIDTH).
REQ-021 SHALL set tkeep_o all-ones on non-last beats.
REQ-022 SHALL, on the last beat, set tkeep_o to the low (len mod KEEP_WIDTH) bits, or all-ones if that remainder is 0.
REQ-023 SHALL hold tlast_o high only on the last beat of each packet.
REQ-024 SHALL drive tuser_o to all-zeros.
REQ-025 SHALL keep a 32-bit sequence counter seq, cleared in LOAD and incremented on each accepted beat (tvalid_o&&tready_i); it wraps 0xFFFFFFFF->0.
REQ-026 SHALL drive 32-bit lane k of tdata_o as seq*(DATA_WIDTH/32)+k, modulo 2^32.
REQ-027 SHALL hold tdata_o, tkeep_o, tlast_o and tvalid_o stable while tvalid_o=1 and tready_i=0; it never drops tvalid_o before acceptance.
REQ-028 SHALL sustain one beat per cycle when tready_i is held at 1, with no bubbles between packets.
REQ-029 SHALL increment pkt_cnt_o when a last beat is accepted; pkt_cnt_o wraps at 16 bits.
REQ-030 SHALL leave SEND for DONE when a last beat is accepted and pkt_cnt_o+1 equals a nonzero latched pkt_num.
REQ-031 SHALL also leave SEND for DONE when a last beat is accepted while run_i=0.
REQ-032 SHALL finish the current packet when run_i is deasserted mid-packet, and never emit a truncated packet.
REQ-033 SHALL, in DONE, assert done_o for exactly one cycle, then go to IDLE.
REQ-034 SHALL ignore run_i changes in LOAD and DONE, and ignore changes to pkt_len_i and pkt_num_i after LOAD.
REQ-035 SHALL run until run_i falls when pkt_num=0.

Reset
REQ-036 SHALL, while rst_i=1, force the FSM to IDLE asynchronously.
REQ-037 SHALL, while rst_i=1, hold tvalid_o, tlast_o, busy_o and done_o at 0.
REQ-038 SHALL, while rst_i=1, hold tdata_o, tkeep_o, tuser_o, pkt_cnt_o, seq and the run edge register at 0.
REQ-039 SHALL, on reset mid-packet, drop tvalid_o immediately with no completion.
REQ-040 SHALL, after reset release with run_i already high, not start until run_i is sampled low and then high again.

Verification
REQ-041 SHALL cover: DATA_WIDTH=64, len=16, num=2, tready=1 -> 4 beats, tlast on beats 2 and 4, lanes 0..7 counting up, done_o pulse, pkt_cnt_o=2.
REQ-042 SHALL cover: len=13 -> 2 beats, last tkeep=0x1F; len=8 -> 1 beat, tkeep=0xFF, tlast=1; len=0 -> 1 beat, tkeep=0x01.
REQ-043 SHALL cover: random tready with 50% duty, len=100, num=5 -> every beat stable while stalled, 65 accepted beats in order, seq=65 at end.
REQ-044 SHALL cover: num=0, len=32, run_i dropped in beat 2 -> beats 3-4 still sent, done_o pulse after beat 4, busy_o then 0.
REQ-045 SHALL cover: rst_i pulsed mid-packet with tready=0 -> tvalid_o=0 the same cycle, and all outputs at reset values.
REQ-046 SHALL cover: seq preset near wrap, 0xFFFFFFFE to 0 -> tdata lanes wrap modulo 2^32 without a glitch.

Source files
------------

// File: rtl/usr_c2h_gen.sv
`default_nettype none
// ============================================================================
// Module      : usr_c2h_gen
// Description : C2H AXI-Stream packet generator. On a rising edge of run_i it
//               latches the packet length and count, then streams packets whose
//               32-bit lanes carry a running sequence number.
// Revision    : 1.0 - initial release
// ============================================================================
module usr_c2h_gen #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  run_i,
  input  logic [15:0]           pkt_len_i,
  input  logic [15:0]           pkt_num_i,
  input  logic                  s0_axis_c2h_tready_i,
  output logic [DATA_WIDTH-1:0] s0_axis_c2h_tdata_o,
  output logic [KEEP_WIDTH-1:0] s0_axis_c2h_tkeep_o,
  output logic [KEEP_WIDTH-1:0] s0_axis_c2h_tuser_o,
  output logic                  s0_axis_c2h_tlast_o,
  output logic                  s0_axis_c2h_tvalid_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [15:0]           pkt_cnt_o
);

  localparam int LANES = DATA_WIDTH / 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_run_d;
  logic        r_run_d2;
  logic        r_seen_low;
  logic [15:0] r_pkt_num;
  logic [15:0] r_pkt_cnt;
  logic [16:0] r_beats;
  logic [16:0] r_beat;
  logic [15:0] r_rem;
  logic [31:0] r_seq;

  logic        w_rise;
  logic        w_accept;
  logic        w_last;
  logic        w_run_end;
  logic [15:0] w_eff_len;
  logic [16:0] w_beats_calc;
  logic [15:0] w_rem_calc;
  logic [31:0] w_lane_base;

  // A start needs run_i seen low since reset, so a level held through reset
  // release does not launch a run.
  assign w_rise       = r_run_d & ~r_run_d2 & r_seen_low;
  assign w_eff_len    = (pkt_len_i == 16'd0) ? 16'd1 : pkt_len_i;
  assign w_beats_calc = ({1'b0, w_eff_len} + 17'(KEEP_WIDTH - 1)) / 17'(KEEP_WIDTH);
  assign w_rem_calc   = w_eff_len % 16'(KEEP_WIDTH);
  assign w_accept     = s0_axis_c2h_tvalid_o & s0_axis_c2h_tready_i;
  assign w_last       = (r_beat == (r_beats - 17'd1));
  assign w_run_end    = ((r_pkt_num != 16'd0) && ((r_pkt_cnt + 16'd1) == r_pkt_num)) || !run_i;
  assign w_lane_base  = r_seq * 32'(LANES);

  // Registered sampling of run_i for edge detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_run_d    <= 1'b0;
      r_run_d2   <= 1'b0;
      r_seen_low <= 1'b0;
    end else begin
      r_run_d    <= run_i;
      r_run_d2   <= r_run_d;
      r_seen_low <= r_seen_low | ~run_i;
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic; a packet is always completed before leaving SEND
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_rise) w_state_next = ST_LOAD;
      ST_LOAD: w_state_next = ST_SEND;
      ST_SEND: if (w_accept && w_last && w_run_end) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Run configuration latch plus beat, packet and sequence counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pkt_num <= 16'd0;
      r_pkt_cnt <= 16'd0;
      r_beats   <= 17'd1;
      r_beat    <= 17'd0;
      r_rem     <= 16'd0;
      r_seq     <= 32'd0;
    end else if (r_state == ST_LOAD) begin
      r_pkt_num <= pkt_num_i;
      r_pkt_cnt <= 16'd0;
      r_beats   <= w_beats_calc;
      r_beat    <= 17'd0;
      r_rem     <= w_rem_calc;
      r_seq     <= 32'd0;
    end else if (w_accept) begin
      r_seq <= r_seq + 32'd1;
      if (w_last) begin
        r_beat    <= 17'd0;
        r_pkt_cnt <= r_pkt_cnt + 16'd1;
      end else begin
        r_beat <= r_beat + 17'd1;
      end
    end
  end

  // Byte enables: full on body beats, partial on a short last beat
  always_comb begin
    s0_axis_c2h_tkeep_o = '0;
    if (s0_axis_c2h_tvalid_o) begin
      if (!w_last || (r_rem == 16'd0)) begin
        s0_axis_c2h_tkeep_o = '1;
      end else begin
        for (int i = 0; i < KEEP_WIDTH; i++) begin
          s0_axis_c2h_tkeep_o[i] = (16'(i) < r_rem);
        end
      end
    end
  end

  // Each 32-bit lane carries seq*LANES + lane index; zero when idle
  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign s0_axis_c2h_tdata_o[k*32 +: 32] =
        s0_axis_c2h_tvalid_o ? (w_lane_base + 32'(k)) : 32'd0;
    end
  endgenerate

  assign s0_axis_c2h_tvalid_o = (r_state == ST_SEND);
  assign s0_axis_c2h_tlast_o  = s0_axis_c2h_tvalid_o & w_last;
  assign s0_axis_c2h_tuser_o  = '0;
  assign busy_o               = (r_state != ST_IDLE);
  assign done_o               = (r_state == ST_DONE);
  assign pkt_cnt_o            = r_pkt_cnt;

endmodule
`default_nettype wire
